frame_feeder: RTL and testbench
===============================

Name: frame_feeder

Overview:
- Upstream stage of the accumulator block: buffers one variable-length byte frame from a source stream (value/last/en/rdy).
- Once the frame closes, issues its length on the accumulator's len method, then streams the buffered bytes on its din method.
- Guarantees len and din are never enabled in the same cycle.

Parameters:
- DATA_W, 8, byte width of stream and din_value.
- DEPTH, 16, frame buffer depth and maximum frame length; legal range 2..255.
- LEN_W, 8, width of len_value.
- CNT_W, 16, width of the frames_sent counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous assert, active-high.
- s_value  in  DATA_W  source byte.
- s_last  in  1  marks the final byte of a frame.
- s_en  in  1  source transfer; asserted only while s_rdy=1.
- s_rdy  out  1  block can accept a source byte.
- len_value  out  LEN_W  frame length to the accumulator.
- len_en  out  1  len transfer strobe.
- len_rdy  in  1  accumulator ready for len.
- din_value  out  DATA_W  data byte to the accumulator.
- din_en  out  1  din transfer strobe.
- din_rdy  in  1  accumulator ready for din.
- busy  out  1  frame in progress.
- frames_sent  out  CNT_W  count of completed frames.
- err_oversize  out  1  sticky; a frame was truncated at DEPTH.

Behaviour:
- Handshake convention: a transfer occurs in any cycle where en=1. Outputs: len_en = (state==SEND_LEN)&&len_rdy; din_en = (state==STREAM)&&din_rdy. Both are combinational from rdy and never both 1.
- States:
  - FILL: s_rdy=1. Each s_en writes s_value to buf[count] and increments count.
  - On accepting a byte with s_last=1, or the DEPTH-th byte: go to SEND_LEN and latch len_reg = count+1.
  - If the DEPTH-th byte has s_last=0: set err_oversize. The remaining source bytes form the next frame.
  - SEND_LEN: s_rdy=0; len_value=len_reg. On len_en, go to STREAM with rd_ptr=0.
  - STREAM: s_rdy=0; din_value = buf[rd_ptr], read combinationally and held stable while din_rdy=0. Each din_en increments rd_ptr.
  - On din_en with rd_ptr==len_reg-1: go to FILL, clear count, increment frames_sent (wraps 2^CNT_W-1 -> 0).
- Latency:
  - Closing byte accepted at cycle N -> len_en earliest N+1.
  - len fire at M -> first din_en earliest M+1.
  - Last din at K -> s_rdy=1 at K+1.
  - Full throughput: one din per cycle while din_rdy=1.
- Frame length is always 1..DEPTH; zero-length frames cannot occur.
- s_en while s_rdy=0 is a protocol error and is ignored (no write, no count change).
- busy = (state!=FILL) || (count!=0).
- Reset, including mid-frame:
  - state=FILL; count, rd_ptr, len_reg, frames_sent, err_oversize = 0.
  - len_en=0, din_en=0, len_value=0, busy=0.
  - s_rdy=1 from the first cycle after RST deasserts.
  - Buffer contents are not reset; din_value is don't-care outside STREAM.
- err_oversize clears only on reset.

Decomposition:
- Shared package holds:
  - state enum (FILL, SEND_LEN, STREAM);
  - default constants DATA_W=8, DEPTH=16, LEN_W=8;
  - a width helper for the count/rd_ptr width, clog2(DEPTH+1).
- One sub-module, frame_buf: DEPTH x DATA_W, synchronous write, asynchronous read, no reset.
- FSM, counters and handshake logic stay in frame_feeder.

Test Plan:
- Frame 0x11,0x22,0x33 (last on 0x33), len_rdy=din_rdy=1 -> one len_en cycle with len_value=3, then din 0x11,0x22,0x33 on 3 consecutive cycles; frames_sent=1; busy low afterwards.
- Same frame, din_rdy toggling 1,0,0,1,0,1 -> bytes delivered in order with no duplicates; din_value constant while din_rdy=0; len_rdy held low 4 cycles delays len_en accordingly.
- 18 bytes 0x00..0x11 with last only on the 18th, DEPTH=16:
  - first frame: len_value=16, bytes 0x00..0x0F, err_oversize=1;
  - second frame: len_value=2, bytes 0x10,0x11;
  - frames_sent=2.
- Single byte 0xA5 with s_last=1 -> len_value=1, one din of 0xA5; s_rdy returns high the cycle after.
- RST pulsed while in STREAM after 2 of 5 bytes -> len_en=din_en=busy=0 immediately; frames_sent=0; a new 2-byte frame then completes normally with len_value=2.
- Checker over all scenarios -> len_en&&din_en never 1; s_rdy=0 in SEND_LEN/STREAM; a forced s_en there leaves count unchanged.

Source files
------------

// File: rtl/frame_feeder_pkg.sv
// Shared types and defaults for the frame feeder: FSM state encoding,
// default widths and the counter width helper.
package frame_feeder_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEND_LEN = 2'd1,
        STREAM   = 2'd2
    } state_t;

    localparam int FF_DATA_W = 8;
    localparam int FF_DEPTH  = 16;
    localparam int FF_LEN_W  = 8;

    // count must hold 0..DEPTH, one more value than a buffer index
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/frame_feeder_if.sv
// Source stream plus the accumulator's len/din methods; master is the
// feeder, slave is whatever sits on the other side of it.
interface frame_feeder_if
    import frame_feeder_pkg::*;
#(
    parameter int DATA_W = FF_DATA_W,
    parameter int LEN_W  = FF_LEN_W
);
    logic [DATA_W-1:0] s_value;
    logic              s_last;
    logic              s_en;
    logic              s_rdy;
    logic [LEN_W-1:0]  len_value;
    logic              len_en;
    logic              len_rdy;
    logic [DATA_W-1:0] din_value;
    logic              din_en;
    logic              din_rdy;

    modport master (
        input  s_value, s_last, s_en, len_rdy, din_rdy,
        output s_rdy, len_value, len_en, din_value, din_en
    );

    modport slave (
        output s_value, s_last, s_en, len_rdy, din_rdy,
        input  s_rdy, len_value, len_en, din_value, din_en
    );

endinterface

// File: rtl/frame_feeder_buf.sv
// Frame storage: synchronous write, combinational read, contents never reset.
module frame_buf
    import frame_feeder_pkg::*;
#(
    parameter int DATA_W = FF_DATA_W,
    parameter int DEPTH  = FF_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_feeder.sv
// Buffers one source frame, then hands its length and bytes to the
// accumulator; len and din strobes are mutually exclusive by state.
module frame_feeder
    import frame_feeder_pkg::*;
#(
    parameter int DATA_W = FF_DATA_W,
    parameter int DEPTH  = FF_DEPTH,
    parameter int LEN_W  = FF_LEN_W,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    frame_feeder_if.master   bus,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent,
    output logic             err_oversize
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    logic [CW-1:0]     count;
    logic [CW-1:0]     rd_ptr;
    logic [LEN_W-1:0]  len_reg;
    logic              s_take;
    logic              len_fire;
    logic              din_fire;
    logic              full_byte;
    logic              last_din;
    logic [DATA_W-1:0] rd_data;

    // s_en outside FILL never reaches the buffer or the counter
    assign bus.s_rdy   = (state == FILL);
    assign s_take      = bus.s_en && bus.s_rdy;
    assign len_fire    = (state == SEND_LEN) && bus.len_rdy;
    assign din_fire    = (state == STREAM) && bus.din_rdy;

    assign bus.len_en    = len_fire;
    assign bus.din_en    = din_fire;
    assign bus.len_value = len_reg;
    assign bus.din_value = rd_data;

    assign full_byte = (count == CW'(DEPTH - 1));
    assign last_din  = (LEN_W'(rd_ptr) == len_reg - LEN_W'(1));
    assign busy      = (state != FILL) || (count != '0);

    frame_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .CLK   (CLK),
        .we    (s_take),
        .waddr (count[AW-1:0]),
        .wdata (bus.s_value),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= FILL;
            count        <= '0;
            rd_ptr       <= '0;
            len_reg      <= '0;
            frames_sent  <= '0;
            err_oversize <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (s_take) begin
                        count <= count + CW'(1);
                        // a full buffer closes the frame; the rest becomes the next one
                        if (bus.s_last || full_byte) begin
                            state   <= SEND_LEN;
                            len_reg <= LEN_W'(count) + LEN_W'(1);
                            if (!bus.s_last) begin
                                err_oversize <= 1'b1;
                            end
                        end
                    end
                end
                SEND_LEN: begin
                    if (len_fire) begin
                        state  <= STREAM;
                        rd_ptr <= '0;
                    end
                end
                STREAM: begin
                    if (din_fire) begin
                        if (last_din) begin
                            state       <= FILL;
                            count       <= '0;
                            frames_sent <= frames_sent + CNT_W'(1);
                        end else begin
                            rd_ptr <= rd_ptr + CW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_feeder.sv
// Directed bench for frame_feeder with a len/din scoreboard fed by a
// small frame model of the source side.
module tb_frame_feeder;

    localparam int DEPTH = 16;

    logic        CLK;
    logic        RST;
    logic        busy;
    logic [15:0] frames_sent;
    logic        err_oversize;

    frame_feeder_if #(.DATA_W(8), .LEN_W(8)) ff_if ();

    frame_feeder #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .LEN_W  (8),
        .CNT_W  (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (ff_if),
        .busy         (busy),
        .frames_sent  (frames_sent),
        .err_oversize (err_oversize)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_len = 0;
    int         n_din = 0;
    int         len_cyc = 0;
    int         last_din_cyc = 0;
    int         frames_exp = 0;
    logic       err_exp = 1'b0;
    logic       hold_chk = 1'b0;
    logic [7:0] exp_len [$];
    logic [7:0] exp_din [$];
    logic [7:0] frm [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // samples the accumulator side between clock edges
    task automatic mon();
        check("len_din_exclusive", {31'd0, ff_if.len_en && ff_if.din_en}, 32'd0);
        if (ff_if.len_en) begin
            n_len++;
            len_cyc = cyc;
            check("s_rdy_in_send_len", {31'd0, ff_if.s_rdy}, 32'd0);
            if (exp_len.size() == 0) check("len_unexpected", exp_len.size(), 1);
            else check("len_value", ff_if.len_value, exp_len.pop_front());
        end
        if (ff_if.din_en) begin
            n_din++;
            last_din_cyc = cyc;
            check("s_rdy_in_stream", {31'd0, ff_if.s_rdy}, 32'd0);
            if (exp_din.size() == 0) check("din_unexpected", exp_din.size(), 1);
            else check("din_value", ff_if.din_value, exp_din.pop_front());
        end else if (hold_chk && exp_din.size() != 0) begin
            check("din_value_held", ff_if.din_value, exp_din[0]);
        end
    endtask

    task automatic step();
        cyc++;
        @(negedge CLK);
        mon();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input logic last);
        for (int i = 0; i < 100 && ff_if.s_rdy !== 1'b1; i++) step();
        check("src_rdy_wait", {31'd0, ff_if.s_rdy}, 32'd1);
        ff_if.s_value = v;
        ff_if.s_last  = last;
        ff_if.s_en    = 1'b1;
        frm.push_back(v);
        if (last || frm.size() == DEPTH) begin
            exp_len.push_back(8'(frm.size()));
            foreach (frm[j]) exp_din.push_back(frm[j]);
            frm.delete();
            frames_exp++;
            if (!last) err_exp = 1'b1;
        end
        step();
        ff_if.s_en   = 1'b0;
        ff_if.s_last = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && busy !== 1'b0; i++) step();
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("frames_sent", frames_sent, frames_exp);
    endtask

    initial begin
        int  b_len;
        int  b_din;
        int  c0;
        int  pat [6];
        logic found;

        pat = '{1, 0, 0, 1, 0, 1};
        RST = 1'b1;
        ff_if.s_value = '0;
        ff_if.s_last  = 1'b0;
        ff_if.s_en    = 1'b0;
        ff_if.len_rdy = 1'b1;
        ff_if.din_rdy = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_len_en", {31'd0, ff_if.len_en}, 32'd0);
        check("rst_din_en", {31'd0, ff_if.din_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frames", frames_sent, 32'd0);
        check("rst_err", {31'd0, err_oversize}, 32'd0);
        check("rst_len_value", ff_if.len_value, 32'd0);
        RST = 1'b0;
        step();
        check("rst_s_rdy", {31'd0, ff_if.s_rdy}, 32'd1);

        // basic 3-byte frame at full throughput
        b_len = n_len;
        b_din = n_din;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        drain(50);
        check("t1_len_count", n_len - b_len, 32'd1);
        check("t1_din_count", n_din - b_din, 32'd3);
        check("t1_din_back_to_back", last_din_cyc - len_cyc, 32'd3);

        // stalled len and toggling din_rdy, with forced s_en while not ready
        ff_if.len_rdy = 1'b0;
        ff_if.din_rdy = 1'b0;
        b_len = n_len;
        b_din = n_din;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                ff_if.s_value = 8'hEE;
                ff_if.s_last  = 1'b1;
                ff_if.s_en    = 1'b1;
            end
            step();
            ff_if.s_en   = 1'b0;
            ff_if.s_last = 1'b0;
        end
        check("t2_len_stalled", n_len - b_len, 32'd0);
        check("t2_s_rdy_send_len", {31'd0, ff_if.s_rdy}, 32'd0);
        check("t2_count_send_len", {27'd0, dut.count}, 32'd3);
        ff_if.len_rdy = 1'b1;
        c0 = cyc + 1;
        step();
        check("t2_len_after_release", len_cyc, c0);
        hold_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ff_if.din_rdy = pat[i][0];
            if (i == 1) begin
                ff_if.s_value = 8'hEE;
                ff_if.s_en    = 1'b1;
            end
            step();
            ff_if.s_en = 1'b0;
            if (i == 1) check("t2_count_stream", {27'd0, dut.count}, 32'd3);
        end
        hold_chk = 1'b0;
        ff_if.din_rdy = 1'b1;
        drain(50);
        check("t2_din_count", n_din - b_din, 32'd3);

        // oversize: 18 bytes split into 16 + 2
        check("t3_err_before", {31'd0, err_oversize}, 32'd0);
        for (int i = 0; i < 18; i++) send(8'(i), i == 17);
        drain(200);
        check("t3_err_after", {31'd0, err_oversize}, {31'd0, err_exp});

        // single-byte frame, s_rdy back the cycle after the last din
        b_din = n_din;
        send(8'hA5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (n_din != b_din) begin
                found = 1'b1;
                check("t4_s_rdy_after_din", {31'd0, ff_if.s_rdy}, 32'd1);
                check("t4_busy_after_din", {31'd0, busy}, 32'd0);
            end
        end
        check("t4_din_seen", {31'd0, found}, 32'd1);
        check("t4_frames", frames_sent, frames_exp);

        // reset in the middle of streaming a 5-byte frame
        ff_if.din_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h51 + 8'(i), i == 4);
        step();
        ff_if.din_rdy = 1'b1;
        step();
        step();
        ff_if.din_rdy = 1'b0;
        RST = 1'b1;
        #1;
        exp_len.delete();
        exp_din.delete();
        frm.delete();
        frames_exp = 0;
        err_exp = 1'b0;
        check("t5_len_en", {31'd0, ff_if.len_en}, 32'd0);
        check("t5_din_en", {31'd0, ff_if.din_en}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_frames", frames_sent, frames_exp);
        check("t5_err", {31'd0, err_oversize}, {31'd0, err_exp});
        step();
        RST = 1'b0;
        #1;
        check("t5_s_rdy", {31'd0, ff_if.s_rdy}, 32'd1);
        ff_if.din_rdy = 1'b1;
        b_len = n_len;
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        drain(50);
        check("t5_len_count", n_len - b_len, 32'd1);

        check("exp_len_empty", exp_len.size(), 32'd0);
        check("exp_din_empty", exp_din.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
